// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy/fill engine: copies length bytes src->dst (read then write per byte)
// or fills length bytes at dst with a constant, driving a single-port combinational-read memory.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic [ADDR_W-1:0] count_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] fill_reg;
  logic              mode_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              rd_en_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Control outputs are registered alongside the state, so each one is set on the
  // edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      count_reg   <= '0;
      hold_reg    <= '0;
      fill_reg    <= '0;
      mode_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rd_en_reg   <= 1'b0;
      wr_en_reg   <= 1'b0;
      addr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            src_ptr_reg <= src_addr;
            dst_ptr_reg <= dst_addr;
            count_reg   <= length;
            mode_reg    <= mode;
            fill_reg    <= fill_value;
            if (length == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else if (mode) begin
              state_reg <= WRITE;
              busy_reg  <= 1'b1;
              wr_en_reg <= 1'b1;
              addr_reg  <= dst_addr;
            end else begin
              state_reg <= READ;
              busy_reg  <= 1'b1;
              rd_en_reg <= 1'b1;
              addr_reg  <= src_addr;
            end
          end
        end
        READ: begin
          hold_reg    <= mem_rdata;
          src_ptr_reg <= src_ptr_reg + 1'b1;
          rd_en_reg   <= 1'b0;
          wr_en_reg   <= 1'b1;
          addr_reg    <= dst_ptr_reg;
          state_reg   <= WRITE;
        end
        WRITE: begin
          dst_ptr_reg <= dst_ptr_reg + 1'b1;
          count_reg   <= count_reg - 1'b1;
          wr_en_reg   <= 1'b0;
          if (count_reg == ADDR_W'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            addr_reg  <= '0;
          end else if (mode_reg) begin
            wr_en_reg <= 1'b1;
            addr_reg  <= dst_ptr_reg + 1'b1;
          end else begin
            state_reg <= READ;
            rd_en_reg <= 1'b1;
            addr_reg  <= src_ptr_reg;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign mem_read_enable  = rd_en_reg;
  assign mem_write_enable = wr_en_reg;
  assign mem_address      = addr_reg;
  // Write data is a pure decode of registers, zero outside WRITE (including during reset).
  assign mem_wdata        = (state_reg == WRITE) ? (mode_reg ? fill_reg : hold_reg) : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus queues expected memory events,
// a negedge monitor pops and compares each observed read/write/done.
module tb_mem_copy_engine;

  localparam int K_RD = 1, K_WR = 2, K_DN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0, dst_addr = '0, length = '0, fill_value = '0;
  logic       busy, done, mem_read_enable, mem_write_enable;
  logic [7:0] mem_address, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int cyc_cnt = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_write_enable) mem[mem_address] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Monitor
  int   mon_kind;
  ev_t  mon_ev;
  logic [7:0] mon_data;
  always @(negedge clk) begin
    if (!reset) begin
      mon_kind = 0;
      if (mem_read_enable) mon_kind = K_RD;
      else if (mem_write_enable) mon_kind = K_WR;
      else if (done) mon_kind = K_DN;
      mon_data = mem_read_enable ? mem_rdata : mem_wdata;
      chk("enables_exclusive", {31'd0, mem_read_enable & mem_write_enable}, 32'd0);
      if (!busy) begin
        chk("idle_address_zero", {24'd0, mem_address}, 32'd0);
        chk("idle_wdata_zero", {24'd0, mem_wdata}, 32'd0);
      end
      if (mon_kind != 0) begin
        $display("cyc %0d: kind=%0d addr=%02h data=%02h", cyc_cnt, mon_kind, mem_address, mon_data);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got kind %0d addr %02h, required no event", mon_kind, mem_address);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("ev_kind", mon_kind, mon_ev.kind);
          chk("ev_addr", {24'd0, mem_address}, {24'd0, mon_ev.addr});
          chk("ev_data", {24'd0, mon_data}, {24'd0, mon_ev.data});
          chk("ev_cycle", cyc_cnt, mon_ev.cyc);
          if (mon_kind == K_RD) chk("read_wdata_zero", {24'd0, mem_wdata}, 32'd0);
        end
      end
    end
  end

  // Issues one transfer (also releasing reset on the same edge), queues the expected
  // events from a sequential byte model, and counts busy cycles.
  task automatic do_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] f,
                         input int exp_busy, input int pulse_at);
    int c;
    int busy_cnt;
    logic [7:0] v;
    busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f; start = 1'b1;
    c = cyc_cnt;
    for (int i = 0; i < int'(n); i++) begin
      if (m) begin
        ref_mem[d + 8'(i)] = f;
        push_ev(K_WR, d + 8'(i), f, c + i + 1);
      end else begin
        v = ref_mem[s + 8'(i)];
        push_ev(K_RD, s + 8'(i), v, c + 2*i + 1);
        ref_mem[d + 8'(i)] = v;
        push_ev(K_WR, d + 8'(i), v, c + 2*i + 2);
      end
    end
    push_ev(K_DN, 8'h00, 8'h00, c + (m ? int'(n) : 2*int'(n)) + 1);
    for (int i = 1; i <= exp_busy + 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (pulse_at != 0 && i == pulse_at) begin
        start = 1'b1; mode = ~m; src_addr = 8'hC0; dst_addr = 8'hD0; length = 8'h05;
      end
      if (pulse_at != 0 && i == pulse_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int c6;
  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B; mem[8'h00] = 8'h7C;
    mem[8'h60] = 8'h01; mem[8'h61] = 8'h02; mem[8'h62] = 8'h03; mem[8'h63] = 8'h04;
    mem[8'h30] = 8'hC1; mem[8'h31] = 8'hC2; mem[8'h32] = 8'hC3; mem[8'h33] = 8'hC4;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_en", {31'd0, mem_read_enable}, 0);
    chk("rst_wr_en", {31'd0, mem_write_enable}, 0);
    chk("rst_address", {24'd0, mem_address}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);

    // Copy 4 bytes; start applied together with reset release
    do_xfer(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 8, 0);
    chk("copy_m80", {24'd0, mem[8'h80]}, 32'h11);
    chk("copy_m81", {24'd0, mem[8'h81]}, 32'h22);
    chk("copy_m82", {24'd0, mem[8'h82]}, 32'h33);
    chk("copy_m83", {24'd0, mem[8'h83]}, 32'h44);

    do_xfer(1'b1, 8'h00, 8'h20, 8'd3, 8'hA5, 3, 0);
    chk("fill_m20", {24'd0, mem[8'h20]}, 32'hA5);
    chk("fill_m21", {24'd0, mem[8'h21]}, 32'hA5);
    chk("fill_m22", {24'd0, mem[8'h22]}, 32'hA5);
    chk("fill_m23_untouched", {24'd0, mem[8'h23]}, 32'h00);

    do_xfer(1'b0, 8'h10, 8'h50, 8'd0, 8'h00, 0, 0);
    chk("zero_len_m50", {24'd0, mem[8'h50]}, 32'h00);

    do_xfer(1'b0, 8'hFE, 8'h40, 8'd3, 8'h00, 6, 0);
    chk("wrap_m40", {24'd0, mem[8'h40]}, 32'h5A);
    chk("wrap_m41", {24'd0, mem[8'h41]}, 32'h6B);
    chk("wrap_m42", {24'd0, mem[8'h42]}, 32'h7C);

    do_xfer(1'b0, 8'h60, 8'h61, 8'd3, 8'h00, 6, 3);
    chk("ovl_m60", {24'd0, mem[8'h60]}, 32'h01);
    chk("ovl_m61", {24'd0, mem[8'h61]}, 32'h01);
    chk("ovl_m62", {24'd0, mem[8'h62]}, 32'h01);
    chk("ovl_m63", {24'd0, mem[8'h63]}, 32'h01);
    chk("ovl_mD0_untouched", {24'd0, mem[8'hD0]}, 32'h00);

    // Reset during the second WRITE of a 4-byte copy 0x30 -> 0x90
    @(negedge clk);
    mode = 1'b0; src_addr = 8'h30; dst_addr = 8'h90; length = 8'd4; start = 1'b1;
    c6 = cyc_cnt;
    push_ev(K_RD, 8'h30, 8'hC1, c6 + 1);
    push_ev(K_WR, 8'h90, 8'hC1, c6 + 2);
    push_ev(K_RD, 8'h31, 8'hC2, c6 + 3);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("second_write_active", {31'd0, mem_write_enable}, 1);
    chk("second_write_addr", {24'd0, mem_address}, 32'h91);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_rd_en", {31'd0, mem_read_enable}, 0);
    chk("abort_wr_en", {31'd0, mem_write_enable}, 0);
    chk("abort_address", {24'd0, mem_address}, 0);
    chk("abort_wdata", {24'd0, mem_wdata}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    ref_mem[8'h90] = 8'hC1;
    chk("abort_m90", {24'd0, mem[8'h90]}, 32'hC1);
    chk("abort_m91", {24'd0, mem[8'h91]}, 32'h00);
    chk("abort_m92", {24'd0, mem[8'h92]}, 32'h00);
    chk("abort_m93", {24'd0, mem[8'h93]}, 32'h00);

    // New start accepted on the first edge after release
    do_xfer(1'b1, 8'h00, 8'h93, 8'd1, 8'h77, 1, 0);
    chk("post_reset_m93", {24'd0, mem[8'h93]}, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the memory data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a transfer.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = copy, 1 = fill.
REQ-007 The block SHALL have port src_addr, input, ADDR_W bits, the first source address (copy mode only).
REQ-008 The block SHALL have port dst_addr, input, ADDR_W bits, the first destination address.
REQ-009 The block SHALL have port length, input, ADDR_W bits, the byte count; 0 means no transfer.
REQ-010 The block SHALL have port fill_value, input, DATA_W bits, the byte written in fill mode.
REQ-011 The block SHALL have port busy, output, 1 bit, high while in READ or WRITE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port mem_read_enable, output, 1 bit, driving the data memory read enable.
REQ-014 The block SHALL have port mem_write_enable, output, 1 bit, driving the data memory write enable.
REQ-015 The block SHALL have port mem_address, output, ADDR_W bits, driving the data memory address.
REQ-016 The block SHALL have port mem_wdata, output, DATA_W bits, driving the data memory data_in.
REQ-017 The block SHALL have port mem_rdata, input, DATA_W bits, from the data memory data_out (combinational read, valid in the same cycle as mem_read_enable).

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-019 In IDLE with start=1, at the clock edge the block SHALL latch src_addr, dst_addr, length, mode and fill_value into internal pointers, counter and registers.
REQ-020 From IDLE with start=1, the next state SHALL be DONE if length=0, else WRITE if mode=1, else READ.
REQ-021 In READ, the block SHALL assert mem_read_enable=1 and drive mem_address=src pointer; at the edge it SHALL capture mem_rdata into a hold register, increment the src pointer and go to WRITE.
REQ-022 In WRITE, the block SHALL assert mem_write_enable=1, drive mem_address=dst pointer, and drive mem_wdata = hold register (copy) or latched fill_value (fill).
REQ-023 At the end of each WRITE edge, the block SHALL increment the dst pointer and decrement the count; it SHALL go to DONE if the count reaches 0, else READ (copy) or WRITE (fill).
REQ-024 In DONE, the block SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 mem_read_enable and mem_write_enable SHALL never both be 1 in the same cycle.
REQ-026 Pointers SHALL wrap modulo 2^ADDR_W (0xFF+1 -> 0x00) without error.
REQ-027 Overlapping ranges SHALL be copied strictly in ascending address order, one byte read then written; no overlap correction is performed.
REQ-028 start SHALL be ignored in READ, WRITE and DONE; inputs are sampled only at the accepting IDLE edge.
REQ-029 Latency: with start accepted at edge E0, a copy of N bytes SHALL hold busy for 2N cycles with done in cycle 2N+1; a fill SHALL hold busy for N cycles with done in cycle N+1.
REQ-030 In IDLE and DONE, the outputs SHALL be mem_read_enable=0, mem_write_enable=0, mem_address=0 and mem_wdata=0.
REQ-031 In READ, mem_wdata SHALL be 0.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, both enables=0, mem_address=0, mem_wdata=0, and all pointers, counter and hold registers to 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no further memory write; writes already committed remain.
REQ-034 The first start SHALL be accepted at the first clock edge after reset deasserts.

Verification
REQ-035 Copy: mem[0x10..0x13]=11,22,33,44 and start with src=0x10, dst=0x80, len=4, mode=0 -> mem[0x80..0x83]=11,22,33,44, busy for 8 cycles, done in cycle 9.
REQ-036 Fill: start with dst=0x20, len=3, mode=1, fill_value=0xA5 -> mem[0x20..0x22]=A5, no read enable ever asserted, done in cycle 4.
REQ-037 Zero length and wrap: len=0 -> done in cycle 1 with no enables; then copy src=0xFE, dst=0x40, len=3 -> reads at FE, FF, 00 in that order.
REQ-038 Overlap and ignored start: mem[0..3]=1,2,3,4, copy src=0, dst=1, len=3 -> mem[0..3]=1,1,1,1; a start pulsed mid-transfer has no effect.
REQ-039 Reset mid-transfer: assert reset during the second WRITE of a 4-byte copy -> outputs are 0 within the same cycle, only the first destination byte is modified, and a new start is accepted after release.
